clock_monitor: RTL and testbench



---
 rtl/clock_monitor_pkg.sv | 13 +
 rtl/clock_monitor_if.sv | 14 +
 rtl/clock_monitor_sync_edge_detect.sv | 29 ++
 rtl/clock_monitor.sv | 89 ++++++++
 tb/tb_clock_monitor.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/clock_monitor_pkg.sv
// clock_monitor_pkg: shared state encoding and default sizing for the clock monitor
package clock_monitor_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_STOPPED = 2'd2;
    localparam int DEFAULT_CNT_WIDTH = 16;
    localparam int DEFAULT_TIMEOUT = 1000;
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        MEASURE = ST_MEASURE,
        STOPPED = ST_STOPPED
    } state_e;
endpackage

// File: rtl/clock_monitor_if.sv
// clock_monitor_if: period result channel between the monitor and its consumer
interface clock_monitor_if
    import clock_monitor_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
);
    logic [CNT_WIDTH-1:0] period;
    logic period_valid;
    logic period_ack;
    logic saturated;
    logic overrun;
    modport master(output period, period_valid, saturated, overrun, input period_ack);
    modport slave(input period, period_valid, saturated, overrun, output period_ack);
endinterface

// File: rtl/clock_monitor_sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser with previous-level flop and edge flags
module sync_edge_detect
    import clock_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic board_clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d;
    // shift the raw input through the chain and remember the last synchronised level
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end
    // synchroniser and previous-level registers
    always_ff @(posedge board_clock) begin
        sync_q <= reset ? '0 : sync_d;
        prev_q <= reset ? 1'b0 : prev_d;
    end
    assign level = sync_q[SYNC_STAGES-1];
    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;
endmodule

// File: rtl/clock_monitor.sv
// clock_monitor: edge strobes, period measurement and stall detection for a slow clock
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic board_clock,
    input  logic reset,
    input  logic clk_in,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic stopped,
    clock_monitor_if.master bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_TIMEOUT = CNT_WIDTH'(TIMEOUT);
    state_e state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
    logic valid_q, valid_d, sat_q, sat_d, overrun_q, overrun_d;
    logic rise_q, rise_d, fall_q, fall_d;
    logic unused_level, rise, fall, publish;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .board_clock,
        .reset,
        .async_in(clk_in),
        .level(unused_level),
        .rise,
        .fall
    );

    // a rise restarts the count (publishing only if a period was in progress); a count reaching the timeout stalls
    always_comb begin
        rise_d = rise;
        fall_d = fall;
        state_d = state_q;
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        publish = 1'b0;
        if (rise) begin
            state_d = MEASURE;
            cnt_d = CNT_WIDTH'(1);
            publish = (state_q == MEASURE);
        end else if (state_q == STOPPED || cnt_q == CNT_TIMEOUT) begin
            state_d = STOPPED;
            cnt_d = cnt_q;
        end
    end

    // single-entry result register with ack handshake and sticky overrun
    always_comb begin
        period_d = publish ? cnt_q : period_q;
        sat_d = publish ? (cnt_q == CNT_MAX) : sat_q;
        valid_d = publish | (valid_q & ~bus.period_ack);
        overrun_d = overrun_q | (publish & valid_q & ~bus.period_ack);
    end

    // all state registers, synchronously cleared
    always_ff @(posedge board_clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            period_q <= '0;
            valid_q <= 1'b0;
            sat_q <= 1'b0;
            overrun_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            period_q <= period_d;
            valid_q <= valid_d;
            sat_q <= sat_d;
            overrun_q <= overrun_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign stopped = (state_q == STOPPED);
    assign bus.period = period_q;
    assign bus.period_valid = valid_q;
    assign bus.saturated = sat_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: two monitor configurations checked against an edge-history model every cycle
module tb_clock_monitor;
    localparam int S = 2;
    logic clk = 1'b0, reset = 1'b1, clk_in = 1'b0, ack = 1'b0;
    logic a_rise, a_fall, a_stop, b_rise, b_fall, b_stop;
    int checks = 0, fails = 0;

    clock_monitor_if #(.CNT_WIDTH(16)) if_a ();
    clock_monitor_if #(.CNT_WIDTH(5)) if_b ();
    assign if_a.period_ack = ack;
    assign if_b.period_ack = ack;

    clock_monitor #(.SYNC_STAGES(S), .CNT_WIDTH(16), .TIMEOUT(20)) dut_a (
        .board_clock(clk), .reset(reset), .clk_in(clk_in),
        .rise_pulse(a_rise), .fall_pulse(a_fall), .stopped(a_stop), .bus(if_a.master)
    );
    clock_monitor #(.SYNC_STAGES(S), .CNT_WIDTH(5), .TIMEOUT(31)) dut_b (
        .board_clock(clk), .reset(reset), .clk_in(clk_in),
        .rise_pulse(b_rise), .fall_pulse(b_fall), .stopped(b_stop), .bus(if_b.master)
    );

    always #5 clk = ~clk;

    int to_cfg[2] = '{20, 31};
    int mx_cfg[2] = '{65535, 31};
    bit v[0:4095];
    int e = -1, rst_edge = -1;
    bit meas[2], stp[2], m_rise[2], m_fall[2], m_valid[2], m_sat[2], m_ovr[2];
    int lr[2], dl[2], m_per[2];

    function automatic bit w(input int i);
        return (i > rst_edge) ? v[i] : 1'b0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit r, f, pub;
        int pv;
        e++;
        v[e] = clk_in;
        if (reset) rst_edge = e;
        for (int n = 0; n < 2; n++) begin
            if (reset) begin
                meas[n] = 0; stp[n] = 0; dl[n] = e + to_cfg[n] + 1;
                m_rise[n] = 0; m_fall[n] = 0; m_valid[n] = 0; m_sat[n] = 0; m_ovr[n] = 0; m_per[n] = 0;
            end else begin
                r = w(e - S) && !w(e - S - 1);
                f = !w(e - S) && w(e - S - 1);
                m_rise[n] = r;
                m_fall[n] = f;
                pub = 0;
                pv = 0;
                if (r) begin
                    if (meas[n]) begin
                        pub = 1;
                        pv = (e - lr[n] > mx_cfg[n]) ? mx_cfg[n] : e - lr[n];
                    end
                    lr[n] = e; meas[n] = 1; stp[n] = 0; dl[n] = e + to_cfg[n];
                end else if (!stp[n] && e == dl[n]) begin
                    stp[n] = 1; meas[n] = 0;
                end
                if (pub) begin
                    m_ovr[n] = m_ovr[n] | (m_valid[n] & !ack);
                    m_valid[n] = 1; m_per[n] = pv; m_sat[n] = (pv == mx_cfg[n]);
                end else if (ack) begin
                    m_valid[n] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("a_rise", a_rise, m_rise[0]);
        chk("a_fall", a_fall, m_fall[0]);
        chk("a_stopped", a_stop, stp[0]);
        chk("a_period", if_a.period, m_per[0]);
        chk("a_valid", if_a.period_valid, m_valid[0]);
        chk("a_saturated", if_a.saturated, m_sat[0]);
        chk("a_overrun", if_a.overrun, m_ovr[0]);
        chk("b_rise", b_rise, m_rise[1]);
        chk("b_fall", b_fall, m_fall[1]);
        chk("b_stopped", b_stop, stp[1]);
        chk("b_period", if_b.period, m_per[1]);
        chk("b_valid", if_b.period_valid, m_valid[1]);
        chk("b_saturated", if_b.saturated, m_sat[1]);
        chk("b_overrun", if_b.overrun, m_ovr[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_rise(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!a_rise && n < 10);
        chk({name, "_rise_seen"}, a_rise, 1);
    endtask

    initial begin
        int nv, bad, na, nb, hold, v2;
        for (int k = 0; k < 3; k++) begin
            clk_in = k[0];
            tick();
            chk("reset_outputs_zero", {a_rise, a_fall, a_stop, if_a.period_valid, if_a.saturated, if_a.overrun, if_a.period}, 0);
        end
        reset = 0;
        clk_in = 0;
        tick();
        chk("post_reset_zero", {a_rise, a_fall, a_stop, if_a.period_valid, if_a.saturated, if_a.overrun, if_a.period}, 0);

        ack = 1;
        nv = 0;
        for (int k = 0; k < 60; k++) begin
            clk_in = (k % 10) < 5;
            tick();
            nv += int'(if_a.period_valid);
        end
        chk("steady_publish_count", nv, 5);
        chk("steady_period", if_a.period, 10);
        chk("steady_overrun", if_a.overrun, 0);

        bad = 0;
        for (int k = 0; k < 24; k++) begin
            clk_in = (k % 2) == 0;
            tick();
            if (k >= 2 && a_rise == a_fall) bad++;
        end
        chk("toggle_alternation_errors", bad, 0);
        chk("toggle_period", if_a.period, 2);

        ack = 0;
        for (int k = 0; k < 24; k++) begin
            clk_in = (k % 8) < 4;
            tick();
        end
        chk("overrun_set", if_a.overrun, 1);
        chk("overrun_period", if_a.period, 8);
        clk_in = 1;
        tick();
        tick();
        ack = 1;
        tick();
        chk("ack_publish_rise", a_rise, 1);
        chk("ack_publish_valid", if_a.period_valid, 1);
        chk("ack_publish_period", if_a.period, 8);
        ack = 0;

        clk_in = 0;
        repeat (4) tick();
        clk_in = 1;
        wait_rise("stall");
        clk_in = 0;
        ack = 1;
        na = 0;
        nb = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (a_stop && na == 0) na = k;
            if (b_stop && nb == 0) nb = k;
        end
        chk("a_stop_delay", na, 20);
        chk("b_stop_delay", nb, 31);
        clk_in = 1;
        wait_rise("restart");
        chk("restart_clears_stopped", a_stop, 0);
        chk("restart_no_publish", if_a.period_valid, 0);
        repeat (3) tick();
        clk_in = 0;
        repeat (6) tick();
        clk_in = 1;
        wait_rise("after_stall");
        chk("after_stall_valid", if_a.period_valid, 1);
        chk("after_stall_period", if_a.period, 12);

        clk_in = 0;
        repeat (4) tick();
        for (int k = 0; k < 93; k++) begin
            clk_in = (k % 31) < 10;
            tick();
        end
        chk("b_saturated_period", if_b.period, 31);
        chk("b_saturated_flag", if_b.saturated, 1);
        chk("a_not_saturated", if_a.saturated, 0);

        hold = 0;
        for (int k = 0; k < 1500; k++) begin
            if (hold == 0) begin
                clk_in = ~clk_in;
                hold = $urandom_range(0, 1) ? $urandom_range(1, 3) : $urandom_range(1, 25);
            end
            hold--;
            ack = $urandom_range(0, 3) != 0;
            reset = $urandom_range(0, 299) == 0;
            tick();
        end
        reset = 0;

        ack = 0;
        for (int k = 0; k < 24; k++) begin
            clk_in = (k % 6) < 3;
            tick();
        end
        chk("pre_reset_valid", if_a.period_valid, 1);
        chk("pre_reset_overrun", if_a.overrun, 1);
        clk_in = 0;
        reset = 1;
        tick();
        reset = 0;
        chk("mid_reset_valid", if_a.period_valid, 0);
        chk("mid_reset_overrun", if_a.overrun, 0);
        chk("mid_reset_period", if_a.period, 0);
        v2 = 1;
        for (int k = 0; k < 12; k++) begin
            clk_in = (k % 6) < 3;
            tick();
            if (k == 2) v2 = int'(if_a.period_valid);
        end
        chk("first_rise_after_reset_no_publish", v2, 0);
        chk("second_rise_period", if_a.period, 6);
        chk("second_rise_valid", if_a.period_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
